// File: rtl/pb_press_debounce_if.sv
// Button/UI signal bundle for pb_press_debounce.
// master: the side that owns the button pin and consumes the debounced events.
// slave:  the debouncer itself.
interface pb_press_debounce_if;
    logic PB;          // raw asynchronous button, 0 = pressed
    logic pressed;     // 1-cycle pulse on accepted press (and repeats)
    logic held;        // level, accepted press until accepted release
    logic long_press;  // 1-cycle pulse, at most once per press

    modport master (
        output PB,
        input  pressed,
        input  held,
        input  long_press
    );

    modport slave (
        input  PB,
        output pressed,
        output held,
        output long_press
    );
endinterface

// File: rtl/pb_press_debounce.sv
// Debounced press detector for an active-low push button.
// Synchronises PB, filters bounce with a stable-sample counter and produces a
// press pulse, a held level and a one-shot long-press pulse, all from flops.
// Optional feature: define PB_AUTO_REPEAT_EN to re-pulse pressed every
// REPEAT_CYCLES cycles once long_press has fired.
module pb_press_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned LONG_CYCLES     = 1000,
    parameter int unsigned REPEAT_CYCLES   = 250
) (
    input logic                clk,
    input logic                rst_n,
    pb_press_debounce_if.slave bus
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_MAX   = HW'(LONG_CYCLES);
    localparam bit            DEB_SINGLE = (DEBOUNCE_CYCLES == 1);

    // Reject parameter values the counters cannot represent.
    if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES == 0) begin : g_bad_long
        $error("LONG_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES == 0) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StHeld,
        StReleaseWait
    } state_e;

    state_e        state;
    logic          pb_meta;
    logic          pb_s;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_inc;
    logic          long_hit;

    // Two-flop synchroniser; resets to "released" so a button held through
    // reset is debounced again and reported as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pb_meta <= 1'b1;
            pb_s    <= 1'b1;
        end else begin
            pb_meta <= bus.PB;
            pb_s    <= pb_meta;
        end
    end

    // Saturating hold counter increment and the one-time crossing into LONG_CYCLES.
    always_comb begin
        hold_inc = hold_cnt;
        long_hit = 1'b0;
        if (hold_cnt != LONG_MAX) begin
            hold_inc = hold_cnt + HW'(1);
            long_hit = (hold_inc == LONG_MAX);
        end
    end

`ifdef PB_AUTO_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic          rep_active;
    logic [RW-1:0] rep_cnt;
    logic          in_hold;
    logic          rel_done;

    // Repeat runs only while the press is live; the edge that returns to IDLE clears it.
    always_comb begin
        in_hold  = (state == StHeld) || (state == StReleaseWait);
        rel_done = 1'b0;
        if (pb_s) begin
            if (state == StReleaseWait && deb_cnt == DEB_LAST) begin
                rel_done = 1'b1;
            end
            if (state == StHeld && DEB_SINGLE) begin
                rel_done = 1'b1;
            end
        end
    end
`endif

    // Debounce FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= StIdle;
            deb_cnt        <= '0;
            hold_cnt       <= '0;
            bus.pressed    <= 1'b0;
            bus.held       <= 1'b0;
            bus.long_press <= 1'b0;
`ifdef PB_AUTO_REPEAT_EN
            rep_active     <= 1'b0;
            rep_cnt        <= '0;
`endif
        end else begin
            bus.pressed    <= 1'b0;
            bus.long_press <= 1'b0;

            case (state)
                StIdle: begin
                    hold_cnt <= '0;
                    if (!pb_s) begin
                        if (DEB_SINGLE) begin
                            state       <= StHeld;
                            deb_cnt     <= '0;
                            bus.pressed <= 1'b1;
                            bus.held    <= 1'b1;
                        end else begin
                            state   <= StPressWait;
                            deb_cnt <= DW'(1);
                        end
                    end
                end

                StPressWait: begin
                    if (pb_s) begin
                        state   <= StIdle;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state       <= StHeld;
                        deb_cnt     <= '0;
                        hold_cnt    <= '0;
                        bus.pressed <= 1'b1;
                        bus.held    <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end

                StHeld: begin
                    hold_cnt       <= hold_inc;
                    bus.long_press <= long_hit;
                    if (pb_s) begin
                        if (DEB_SINGLE) begin
                            state    <= StIdle;
                            deb_cnt  <= '0;
                            bus.held <= 1'b0;
                        end else begin
                            state   <= StReleaseWait;
                            deb_cnt <= DW'(1);
                        end
                    end
                end

                StReleaseWait: begin
                    // hold_cnt keeps counting so a release bounce does not restart it.
                    hold_cnt       <= hold_inc;
                    bus.long_press <= long_hit;
                    if (!pb_s) begin
                        state   <= StHeld;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state    <= StIdle;
                        deb_cnt  <= '0;
                        bus.held <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end

                default: begin
                    state    <= StIdle;
                    deb_cnt  <= '0;
                    hold_cnt <= '0;
                    bus.held <= 1'b0;
                end
            endcase

`ifdef PB_AUTO_REPEAT_EN
            if (!in_hold || rel_done) begin
                rep_active <= 1'b0;
                rep_cnt    <= '0;
            end else if (long_hit) begin
                rep_active <= 1'b1;
                rep_cnt    <= '0;
            end else if (rep_active) begin
                if (rep_cnt == REP_LAST) begin
                    rep_cnt     <= '0;
                    bus.pressed <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt + RW'(1);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_pb_press_debounce.sv
// Directed bench for pb_press_debounce (DEBOUNCE=4, LONG=20, REPEAT=8).
// Each step is one clock; outputs are sampled 1 time unit after the rising edge,
// and PB changes at that same point so the next edge captures it.
// With this timing a PB change before step 1 shows on the outputs at step 6.
module tb_pb_press_debounce;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;
    localparam int unsigned REP  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    pb_press_debounce_if bus ();

    pb_press_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected pressed for a press whose PB fell before step 1 and that returns
    // to IDLE at step idle_at: first pulse at 6, repeats every 8 from 34.
    function automatic bit exp_pressed(int c, int idle_at);
        bit e;
        e = (c == 6) && (c < idle_at);
`ifdef PB_AUTO_REPEAT_EN
        if (c >= 34 && c < idle_at && ((c - 34) % 8) == 0) e = 1'b1;
`endif
        return e;
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        bus.PB = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.pressed !== 1'b0) begin
            errors++; $display("FAIL reset_pressed got=%b exp=0", bus.pressed);
        end
        checks++;
        if (bus.held !== 1'b0) begin
            errors++; $display("FAIL reset_held got=%b exp=0", bus.held);
        end
        checks++;
        if (bus.long_press !== 1'b0) begin
            errors++; $display("FAIL reset_long got=%b exp=0", bus.long_press);
        end
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            checks++;
            if ({bus.pressed, bus.held, bus.long_press} !== 3'b000) begin
                errors++;
                $display("FAIL idle_quiet cyc=%0d got p/h/l=%b%b%b exp=000",
                         cyc, bus.pressed, bus.held, bus.long_press);
            end
        end
    endtask

    // Press, hold ~30 cycles after pressed, release at step 35 (IDLE at 41).
    task automatic test_press_and_long();
        bit ep, eh, el;
        cyc    = 0;
        bus.PB = 1'b0;
        for (int i = 0; i < 45; i++) begin
            if (cyc == 35) bus.PB = 1'b1;
            step();
            ep = exp_pressed(cyc, 41);
            eh = (cyc >= 6) && (cyc < 41);
            el = (cyc == 26);
            checks++;
            if (bus.pressed !== ep) begin
                errors++; $display("FAIL press_pulse cyc=%0d got=%b exp=%b", cyc, bus.pressed, ep);
            end
            checks++;
            if (bus.held !== eh) begin
                errors++; $display("FAIL press_held cyc=%0d got=%b exp=%b", cyc, bus.held, eh);
            end
            checks++;
            if (bus.long_press !== el) begin
                errors++;
                $display("FAIL press_long cyc=%0d got=%b exp=%b", cyc, bus.long_press, el);
            end
        end
    endtask

    // Low 2, high 1, low 2, then high: must be rejected. A clean press
    // afterwards with normal latency shows the FSM went back to IDLE.
    task automatic test_bounce();
        int seen_p, seen_h;
        seen_p = 0;
        seen_h = 0;
        cyc    = 0;
        for (int i = 0; i < 15; i++) begin
            bus.PB = (cyc == 2 || cyc >= 5) ? 1'b1 : 1'b0;
            step();
            if (bus.pressed === 1'b1) seen_p++;
            if (bus.held === 1'b1) seen_h++;
        end
        checks++;
        if (seen_p !== 0) begin
            errors++; $display("FAIL bounce_pressed got=%0d pulses exp=0", seen_p);
        end
        checks++;
        if (seen_h !== 0) begin
            errors++; $display("FAIL bounce_held got=%0d cycles exp=0", seen_h);
        end
        cyc    = 0;
        bus.PB = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus.pressed !== (cyc == 6)) begin
                errors++;
                $display("FAIL bounce_idle_press cyc=%0d got=%b exp=%b", cyc, bus.pressed, cyc == 6);
            end
        end
        bus.PB = 1'b1;
        repeat (8) step();
        checks++;
        if (bus.held !== 1'b0) begin
            errors++; $display("FAIL bounce_release got=%b exp=0", bus.held);
        end
    endtask

    // Release bounce: PB high for 2 cycles mid-hold, then final release at step 30.
    task automatic test_release_bounce();
        bit ep, eh, el;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            bus.PB = (cyc == 12 || cyc == 13 || cyc >= 30) ? 1'b1 : 1'b0;
            step();
            ep = exp_pressed(cyc, 36);
            eh = (cyc >= 6) && (cyc < 36);
            el = (cyc == 26);
            checks++;
            if (bus.pressed !== ep) begin
                errors++; $display("FAIL relb_pulse cyc=%0d got=%b exp=%b", cyc, bus.pressed, ep);
            end
            checks++;
            if (bus.held !== eh) begin
                errors++; $display("FAIL relb_held cyc=%0d got=%b exp=%b", cyc, bus.held, eh);
            end
            checks++;
            if (bus.long_press !== el) begin
                errors++; $display("FAIL relb_long cyc=%0d got=%b exp=%b", cyc, bus.long_press, el);
            end
        end
    endtask

    // Async reset while held; PB stays low so the press is reported again.
    task automatic test_reset_mid_press();
        cyc    = 0;
        bus.PB = 1'b0;
        repeat (10) step();
        checks++;
        if (bus.held !== 1'b1) begin
            errors++; $display("FAIL midrst_pre_held got=%b exp=1", bus.held);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.pressed, bus.held, bus.long_press} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_async got p/h/l=%b%b%b exp=000",
                     bus.pressed, bus.held, bus.long_press);
        end
        #2;
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus.pressed !== (cyc == 6)) begin
                errors++;
                $display("FAIL midrst_repress cyc=%0d got=%b exp=%b", cyc, bus.pressed, cyc == 6);
            end
            checks++;
            if (bus.held !== (cyc >= 6)) begin
                errors++;
                $display("FAIL midrst_held cyc=%0d got=%b exp=%b", cyc, bus.held, cyc >= 6);
            end
        end
        bus.PB = 1'b1;
        repeat (10) step();
    endtask

    // Hold 50 cycles: one pressed by default, plus repeats at 34/42/50 with auto-repeat.
    task automatic test_long_hold_repeat();
        int n_p, exp_n;
        bit ep;
        n_p = 0;
`ifdef PB_AUTO_REPEAT_EN
        exp_n = 4;
`else
        exp_n = 1;
`endif
        cyc = 0;
        for (int i = 0; i < 60; i++) begin
            bus.PB = (cyc >= 50) ? 1'b1 : 1'b0;
            step();
            ep = exp_pressed(cyc, 56);
            if (bus.pressed === 1'b1) n_p++;
            checks++;
            if (bus.pressed !== ep) begin
                errors++; $display("FAIL repeat_pulse cyc=%0d got=%b exp=%b", cyc, bus.pressed, ep);
            end
            checks++;
            if (bus.long_press !== (cyc == 26)) begin
                errors++;
                $display("FAIL repeat_long cyc=%0d got=%b exp=%b", cyc, bus.long_press, cyc == 26);
            end
        end
        checks++;
        if (n_p !== exp_n) begin
            errors++; $display("FAIL repeat_count got=%0d exp=%0d", n_p, exp_n);
        end
        checks++;
        if (bus.held !== 1'b0) begin
            errors++; $display("FAIL repeat_release got=%b exp=0", bus.held);
        end
    endtask

    initial begin
        bus.PB = 1'b1;
        test_reset();
        test_press_and_long();
        repeat (5) step();
        test_bounce();
        test_release_bounce();
        repeat (5) step();
        test_reset_mid_press();
        test_long_hold_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
